// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
package rr_arb_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Index width for n entries; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate-priority encoder: first set req bit at or above base, wrapping.
module rr_priority_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] base,
  output logic [CW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    int unsigned idx;
    logic [CW-1:0] sel;
    logic found;
    idx     = 0;
    sel     = '0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // Explicit wrap keeps non-power-of-two N correct.
      idx = 32'(base) + k;
      if (idx >= N) idx = idx - N;
      sel = CW'(idx);
      if (!found && req[sel]) begin
        found   = 1'b1;
        gnt_idx = sel;
      end
    end
    any = found;
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin N-way arbiter with a registered output stage.
// Define RR_ARB_LOCK_EN to build the BEATS-long burst lock.
module rr_lock_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned BEATS = 2,
  parameter int unsigned CW    = idx_w(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   io_in_valid,
  input  logic [N*W-1:0] io_in_bits,
  output logic [N-1:0]   io_in_ready,
  output logic           io_out_valid,
  output logic [W-1:0]   io_out_bits,
  input  logic           io_out_ready,
  output logic [CW-1:0]  io_chosen,
  output logic           io_locked
);

  logic [CW-1:0] last_q;
  logic [CW-1:0] base_c;
  logic [N-1:0]  eligible_c;
  logic [CW-1:0] gnt_idx_c;
  logic          any_c;
  logic          pipe_ready_c;
  logic          fire_c;
  logic [N-1:0]  in_ready_c;

  assign base_c = (last_q == CW'(N - 1)) ? '0 : last_q + CW'(1);

  rr_priority_pick #(
    .N  (N),
    .CW (CW)
  ) u_pick (
    .req     (eligible_c),
    .base    (base_c),
    .gnt_idx (gnt_idx_c),
    .any     (any_c)
  );

  // No transfer is accepted while reset is held, so ready stays low.
  assign pipe_ready_c = !io_out_valid || io_out_ready;
  assign fire_c       = reset && pipe_ready_c && any_c;

  always_comb begin
    in_ready_c = '0;
    if (fire_c) in_ready_c[gnt_idx_c] = 1'b1;
  end

  assign io_in_ready = in_ready_c;

  // Output register: fill, drain, or fill and drain in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      io_out_valid <= 1'b0;
      io_out_bits  <= '0;
      io_chosen    <= '0;
      last_q       <= CW'(N - 1);
    end else if (fire_c) begin
      io_out_valid <= 1'b1;
      io_out_bits  <= io_in_bits[32'(gnt_idx_c)*W +: W];
      io_chosen    <= gnt_idx_c;
      last_q       <= gnt_idx_c;
    end else if (io_out_ready) begin
      io_out_valid <= 1'b0;
    end
  end

`ifdef RR_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(BEATS + 1);
  localparam bit          MULTI = (BEATS > 1);

  lock_state_e       state_q, state_d;
  logic [CW-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= UNLOCKED;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt counts beats still owed by the owner after the current one.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      UNLOCKED: begin
        if (fire_c && MULTI) begin
          state_d = LOCKED;
          owner_d = gnt_idx_c;
          cnt_d   = CNT_W'(BEATS - 1);
        end
      end
      LOCKED: begin
        if (fire_c) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = UNLOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_comb begin
    eligible_c = io_in_valid;
    if (state_q == LOCKED) begin
      eligible_c          = '0;
      eligible_c[owner_q] = io_in_valid[owner_q];
    end
  end

  assign io_locked = (state_q == LOCKED);
`else
  logic unused_beats;

  assign eligible_c   = io_in_valid;
  assign io_locked    = 1'b0;
  assign unused_beats = ^32'(BEATS);
`endif

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Scoreboard bench for rr_lock_arbiter; expectations follow RR_ARB_LOCK_EN.
module tb_rr_lock_arbiter;

`ifdef RR_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] chosen;
    logic [7:0] bits;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  io_in_valid;
  logic [31:0] io_in_bits;
  logic [3:0]  io_in_ready;
  logic        io_out_valid;
  logic [7:0]  io_out_bits;
  logic        io_out_ready;
  logic [1:0]  io_chosen;
  logic        io_locked;

  beat_t sb[$];
  beat_t exp_beat;
  int    checks = 0;
  int    passed = 0;

  rr_lock_arbiter #(.N(4), .W(8), .BEATS(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_bits   (io_in_bits),
    .io_in_ready  (io_in_ready),
    .io_out_valid (io_out_valid),
    .io_out_bits  (io_out_bits),
    .io_out_ready (io_out_ready),
    .io_chosen    (io_chosen),
    .io_locked    (io_locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int chosen, input int bits);
    beat_t b;
    b.chosen = 2'(chosen);
    b.bits   = 8'(bits);
    sb.push_back(b);
  endtask

  task automatic pulse_reset();
    io_in_valid = 4'b0000;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Monitor: every accepted output beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && io_out_valid && io_out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_beat", {22'd0, io_chosen, io_out_bits}, 32'hffff_ffff);
      end else begin
        exp_beat = sb.pop_front();
        check("sb_chosen", 32'(io_chosen), 32'(exp_beat.chosen));
        check("sb_bits", 32'(io_out_bits), 32'(exp_beat.bits));
      end
    end
  end

  initial begin
    int nbeats;
    reset        = 1'b0;
    io_in_valid  = 4'b1111;
    io_in_bits   = 32'h13121110;
    io_out_ready = 1'b1;

    // Reset held two cycles with every requester valid.
    tick();
    tick();
    check("rst_out_valid", 32'(io_out_valid), 32'd0);
    check("rst_chosen", 32'(io_chosen), 32'd0);
    check("rst_locked", 32'(io_locked), 32'd0);
    check("rst_in_ready", 32'(io_in_ready), 32'b0000);
    reset = 1'b1;
    #1;
    check("first_ready_req0", 32'(io_in_ready), 32'b0001);

    // Round robin over all valid requesters, one beat per cycle.
    nbeats = LOCK ? 8 : 5;
    for (int k = 0; k < nbeats; k++) begin
      if (LOCK) push((k / 2) % 4, 'h10 + (k / 2) % 4);
      else      push(k % 4, 'h10 + k % 4);
    end
    for (int k = 0; k < nbeats; k++) begin
      tick();
      if (k == nbeats - 1) io_in_valid = 4'b0000;
      #1;
      check("rr_out_valid", 32'(io_out_valid), 32'd1);
      check("rr_locked", 32'(io_locked), 32'(LOCK && (k % 2 == 0)));
    end
    tick();
    check("rr_drained", 32'(io_out_valid), 32'd0);
    check("rr_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure: single capture, then hold, then drain and refill together.
    pulse_reset();
    io_in_bits   = 32'h131211A5;
    io_in_valid  = 4'b0001;
    io_out_ready = 1'b0;
    push(0, 'hA5);
    push(0, 'h5A);
    tick();
    #1;
    check("bp_out_valid", 32'(io_out_valid), 32'd1);
    check("bp_bits", 32'(io_out_bits), 32'hA5);
    check("bp_chosen", 32'(io_chosen), 32'd0);
    check("bp_in_ready", 32'(io_in_ready), 32'b0000);
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      check("bp_hold_bits", 32'(io_out_bits), 32'hA5);
      check("bp_hold_chosen", 32'(io_chosen), 32'd0);
      check("bp_hold_ready", 32'(io_in_ready), 32'b0000);
    end
    io_out_ready = 1'b1;
    io_in_bits   = 32'h1312115A;
    #1;
    check("bp_release_ready", 32'(io_in_ready), 32'b0001);
    tick();
    io_in_valid = 4'b0000;
    #1;
    check("bp_refill_valid", 32'(io_out_valid), 32'd1);
    check("bp_refill_bits", 32'(io_out_bits), 32'h5A);
    tick();
    check("bp_drained", 32'(io_out_valid), 32'd0);
    io_in_bits = 32'h13121110;

    // Owner stall: requester 1 owns the lock, then drops valid for two cycles.
    pulse_reset();
    io_in_valid = 4'b0110;
    #1;
    check("stall_first_ready", 32'(io_in_ready), 32'b0010);
    if (LOCK) begin
      push(1, 'h11); push(1, 'h11); push(2, 'h12);
    end else begin
      push(1, 'h11); push(2, 'h12); push(2, 'h12); push(1, 'h11); push(2, 'h12);
    end
    tick();
    io_in_valid = 4'b0100;
    #1;
    for (int c = 0; c < 2; c++) begin
      check("stall_locked", 32'(io_locked), 32'(LOCK));
      check("stall_ready", 32'(io_in_ready), LOCK ? 32'b0000 : 32'b0100);
      tick();
      if (c == 1) io_in_valid = 4'b0110;
      #1;
    end
    check("stall_owner_back", 32'(io_in_ready), 32'b0010);
    tick();
    #1;
    check("stall_unlocked", 32'(io_locked), 32'd0);
    check("stall_next_req2", 32'(io_in_ready), 32'b0100);
    tick();
    io_in_valid = 4'b0000;
    tick();
    check("stall_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of a burst with a beat held in the output register.
    pulse_reset();
    io_in_valid  = 4'b1111;
    io_out_ready = 1'b0;
    tick();
    #1;
    check("mid_out_valid", 32'(io_out_valid), 32'd1);
    check("mid_locked", 32'(io_locked), 32'(LOCK));
    reset = 1'b0;
    #1;
    check("mid_rst_ready", 32'(io_in_ready), 32'b0000);
    tick();
    #1;
    check("mid_rst_valid", 32'(io_out_valid), 32'd0);
    check("mid_rst_locked", 32'(io_locked), 32'd0);
    check("mid_rst_chosen", 32'(io_chosen), 32'd0);
    reset        = 1'b1;
    io_out_ready = 1'b1;
    push(0, 'h10);
    #1;
    check("mid_regrant_ready", 32'(io_in_ready), 32'b0001);
    tick();
    io_in_valid = 4'b0000;
    #1;
    check("mid_regrant_valid", 32'(io_out_valid), 32'd1);
    tick();
    #1;
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rr_lock_arbiter.md
# rr_lock_arbiter

Round-robin N-way arbiter with a registered output stage and optional burst lock. It sits in front of a shared ready/valid consumer and replaces the fixed-priority arbiter wherever starvation or beat interleaving is unacceptable. It adds one cycle of latency and sustains one beat per cycle.

## Interface
- `N`, 4: number of requesters; N ≥ 2.
- `W`, 8: payload width in bits.
- `BEATS`, 2: transfers per locked burst; BEATS ≥ 1.
- `CW`, $clog2(N): width of `io_chosen` (derived).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset. One clock; reset is synchronous and active-low.
- `io_in_valid`  in  N  per-requester valid.
- `io_in_bits`  in  N*W  per-requester payload; requester i occupies bits [i*W +: W].
- `io_in_ready`  out  N  per-requester ready; one-hot or zero.
- `io_out_valid`  out  1  registered output valid.
- `io_out_bits`  out  W  registered payload.
- `io_out_ready`  in  1  consumer ready.
- `io_chosen`  out  CW  index of the requester whose beat sits in the output register.
- `io_locked`  out  1  burst lock active (constant 0 without the lock feature).

## Operation
- Output register states:
  - `pipe_ready = !io_out_valid | io_out_ready`.
  - Fill and drain in the same cycle is legal.
- Grant selection:
  - Unlocked: the grant goes to the first valid requester scanning from `(last+1) mod N` upward, with wrap-around.
  - Locked: only `owner` is eligible.
- Ready: `io_in_ready[g] = pipe_ready & io_in_valid[g]`; every other bit is 0. Ready never asserts for an invalid requester.
- Fire (a transfer from requester g):
  - Output register loads `io_out_bits <= bits[g]`, `io_chosen <= g`, `io_out_valid <= 1`.
  - `last <= g`.
- Drain: when `io_out_valid & io_out_ready` and no new fire, `io_out_valid <= 0`. `io_out_bits` and `io_chosen` hold their values.
- Lock FSM (feature enabled), two states:
  - UNLOCKED → LOCKED: on a fire when BEATS > 1; sets `owner <= g` and `cnt <= BEATS-1`.
  - LOCKED, owner fires: `cnt` decrements. A fire with `cnt == 1` returns to UNLOCKED in the same edge.
  - LOCKED, owner valid low: the lock holds and other requesters stall. There is no timeout.
  - BEATS == 1: the FSM never leaves UNLOCKED.
- Widths:
  - `cnt` is $clog2(BEATS+1) bits.
  - The pointer wraps modulo N; for N not a power of two, compare against N-1 explicitly.

## Timing
- Reset values:
  - `io_out_valid=0`, `io_out_bits=0`, `io_chosen=0`, `io_locked=0`.
  - `last=N-1`, so requester 0 has first priority.
  - `cnt=0`, UNLOCKED.
  - `io_in_ready` is combinational and therefore 0 while no input is valid.
- Latency: the input fire at edge k makes `io_out_valid` visible from cycle k+1.
- Throughput: one beat per cycle while `io_out_ready=1`.
- `io_in_ready` is combinational from `io_in_valid`, `io_out_valid`, `io_out_ready` and state. It has no path from `io_in_bits`.
- `io_out_bits` and `io_chosen` are stable while `io_out_valid & !io_out_ready`.
- Reset asserted mid-burst or with a beat held: the held beat is dropped, the lock clears, and the pointer returns to N-1 on that edge.

## Configuration
- `RR_ARB_LOCK_EN` defined: the burst-lock FSM, `owner`, `cnt` and a live `io_locked` are built.
- `RR_ARB_LOCK_EN` undefined:
  - Every beat is arbitrated independently, exactly as BEATS=1.
  - `io_locked` is tied to 0.
  - The `BEATS` parameter is ignored.

## Structure
- Shared package `rr_arb_pkg` holds:
  - The `lock_state_e` enum (UNLOCKED, LOCKED).
  - The `idx_w(n)` width function.
- Sub-module `rr_priority_pick`: purely combinational rotate-priority encoder.
  - Inputs: `req[N]`, `base`.
  - Outputs: `gnt_idx`, `any`.
  - It is also instantiated by future schedulers.

## Test plan
- Reset: hold `reset=0` 2 cycles with all valids high → `io_out_valid=0`, `io_chosen=0`, `io_locked=0`, `io_in_ready=0000`. First post-reset grant goes to requester 0.
- Round-robin, lock off: all 4 valid, bits 0x10+i, `io_out_ready=1` → `io_chosen` sequence 0,1,2,3,0; `io_out_bits` 0x10,0x11,0x12,0x13,0x10; one beat per cycle.
- Burst lock, BEATS=2: all valid → `io_chosen` 0,0,1,1,2,2,3,3. `io_locked=1` in the cycle after each first beat.
- Backpressure: only in_0 valid with 0xA5, `io_out_ready=0` for 3 cycles → one capture, then `io_in_ready[0]=0`; out holds 0xA5 and chosen 0. Raising ready gives a drain and refill in the same cycle.
- Owner stall: requesters 1 and 2 valid, owner 1 drops valid for 2 cycles after its first beat → `io_in_ready[2]=0` throughout and `io_locked=1`. Owner returns and completes its second beat, then requester 2 is granted.
- Reset mid-burst: `reset=0` while LOCKED with `io_out_valid=1` → next cycle `io_out_valid=0` and `io_locked=0`. With all valid, the next grant goes to requester 0.
